// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial ALU: op encodings, FSM states,
// and the operand-width legality rule.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_ASL  = 4'b1011;
  localparam logic [3:0] OP_OR   = 4'b1100;
  localparam logic [3:0] OP_AND  = 4'b1101;
  localparam logic [3:0] OP_EOR  = 4'b1110;
  localparam logic [3:0] OP_PASS = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

  // Operands are processed one 4-bit digit at a time, so the width must
  // split into whole nibbles; the digit counter covers at most 8 digits.
  function automatic bit width_legal(input int unsigned w);
    return (w % 4 == 0) && (w >= 4) && (w <= 32);
  endfunction

endpackage

// File: rtl/nibble_serial_alu_if.sv
// Request/result bundle between the CPU core (master) and the shared ALU (slave).
interface nibble_serial_alu_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             start;
  logic [3:0]       op;
  logic             right;
  logic [WIDTH-1:0] ai;
  logic [WIDTH-1:0] bi;
  logic             ci;
  logic             bcd;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             co;
  logic             hc;
  logic             v;
  logic             n;
  logic             z;

  modport master (
    output start, op, right, ai, bi, ci, bcd,
    input  busy, done, out, co, hc, v, n, z
  );

  modport slave (
    input  start, op, right, ai, bi, ci, bcd,
    output busy, done, out, co, hc, v, n, z
  );

endinterface

// File: rtl/bcd_nibble_adder.sv
// One 4-bit adder digit with optional decimal adjust for add or subtract.
// bin_carry/bin_msb expose the uncorrected sum for overflow detection.
module bcd_nibble_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  input  logic       bcd,
  input  logic       sub,
  output logic [3:0] digit,
  output logic       carry,
  output logic       bin_carry,
  output logic       bin_msb
);

  logic [4:0] sum;

  assign sum       = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
  assign bin_carry = sum[4];
  assign bin_msb   = sum[3];

  // Decimal add corrects sums above 9; decimal subtract corrects on borrow.
  always_comb begin
    digit = sum[3:0];
    carry = sum[4];
    if (bcd && !sub && (sum > 5'd9)) begin
      digit = sum[3:0] + 4'd6;
      carry = 1'b1;
    end else if (bcd && sub && !sum[4]) begin
      digit = sum[3:0] + 4'd10;
      carry = 1'b0;
    end
  end

endmodule

// File: rtl/nibble_serial_alu.sv
// Shared multi-cycle ALU: logic/shift stage at request time, then a
// nibble-serial (LSB-first) adder with decimal correction, one digit per
// enabled clock. Results and flags update only when the operation completes.
module nibble_serial_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rdy,
  nibble_serial_alu_if.slave bus
);

  localparam int unsigned DIGITS = WIDTH / 4;
  localparam logic [2:0]  K_LAST = 3'(DIGITS - 1);

  if (!width_legal(WIDTH)) begin : g_width_check
    $error("nibble_serial_alu: WIDTH must be a multiple of 4 in 4..32");
  end

  alu_state_t       state_q, state_d;
  logic [2:0]       k_q, k_d;
  logic [WIDTH:0]   l_q, l_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic             dadj_q, dadj_d;
  logic             dsub_q, dsub_d;
  logic             amsb_q, amsb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             hc_s_q, hc_s_d;
  logic             co_s_q, co_s_d;
  logic             v_s_q, v_s_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             co_q, co_d;
  logic             hc_q, hc_d;
  logic             v_q, v_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   stage_l;
  logic [WIDTH-1:0] stage_b;
  logic             stage_ci;
  logic [4:0]       dig_lsb;
  logic [3:0]       dig_a, dig_b, digit;
  logic             carry, bin_carry, bin_msb;

  assign dig_lsb = {k_q, 2'b00};
  assign dig_a   = l_q[dig_lsb +: 4];
  assign dig_b   = b_q[dig_lsb +: 4];

  bcd_nibble_adder u_adder (
    .a         (dig_a),
    .b         (dig_b),
    .ci        (c_q),
    .bcd       (dadj_q),
    .sub       (dsub_q),
    .digit     (digit),
    .carry     (carry),
    .bin_carry (bin_carry),
    .bin_msb   (bin_msb)
  );

  // Logic/rotate stage and effective B operand, evaluated from the live request.
  always_comb begin
    stage_l = '0;
    stage_b = '0;
    unique case (bus.op[1:0])
      OP_OR[1:0]:  stage_l[WIDTH-1:0] = bus.ai | bus.bi;
      OP_AND[1:0]: stage_l[WIDTH-1:0] = bus.ai & bus.bi;
      OP_EOR[1:0]: stage_l[WIDTH-1:0] = bus.ai ^ bus.bi;
      default:     stage_l[WIDTH-1:0] = bus.ai;
    endcase
    // Rotate keeps ai[0] in the extra top bit; it joins the carry at the last digit.
    if (bus.right) stage_l = {bus.ai[0], bus.ci, bus.ai[WIDTH-1:1]};
    unique case (bus.op[3:2])
      OP_ADD[3:2]: stage_b = bus.bi;
      OP_SUB[3:2]: stage_b = ~bus.bi;
      OP_ASL[3:2]: stage_b = stage_l[WIDTH-1:0];
      default:     stage_b = '0;
    endcase
    stage_ci = bus.ci && !bus.right && (bus.op[3:2] != OP_PASS[3:2]);
  end

  // FSM next state plus datapath next values; registers are frozen by rdy.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    l_d     = l_q;
    b_d     = b_q;
    c_d     = c_q;
    dadj_d  = dadj_q;
    dsub_d  = dsub_q;
    amsb_d  = amsb_q;
    acc_d   = acc_q;
    hc_s_d  = hc_s_q;
    co_s_d  = co_s_q;
    v_s_d   = v_s_q;
    out_d   = out_q;
    co_d    = co_q;
    hc_d    = hc_q;
    v_d     = v_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && !done_q) begin
          l_d     = stage_l;
          b_d     = stage_b;
          c_d     = stage_ci;
          dadj_d  = bus.bcd && ((bus.op == OP_ADD) || (bus.op == OP_SUB));
          dsub_d  = (bus.op == OP_SUB);
          amsb_d  = bus.ai[WIDTH-1];
          k_d     = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        acc_d[dig_lsb +: 4] = digit;
        c_d = carry;
        if (k_q == 3'd0) hc_s_d = carry;
        if (k_q == K_LAST) begin
          co_s_d  = carry ^ l_q[WIDTH];
          v_s_d   = amsb_q ^ b_q[WIDTH-1] ^ bin_carry ^ bin_msb;
          state_d = ST_DONE;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      ST_DONE: begin
        out_d   = acc_q;
        co_d    = co_s_q;
        hc_d    = hc_s_q;
        v_d     = v_s_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      l_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      dadj_q  <= 1'b0;
      dsub_q  <= 1'b0;
      amsb_q  <= 1'b0;
      acc_q   <= '0;
      hc_s_q  <= 1'b0;
      co_s_q  <= 1'b0;
      v_s_q   <= 1'b0;
      out_q   <= '0;
      co_q    <= 1'b0;
      hc_q    <= 1'b0;
      v_q     <= 1'b0;
      done_q  <= 1'b0;
    end else if (rdy) begin
      state_q <= state_d;
      k_q     <= k_d;
      l_q     <= l_d;
      b_q     <= b_d;
      c_q     <= c_d;
      dadj_q  <= dadj_d;
      dsub_q  <= dsub_d;
      amsb_q  <= amsb_d;
      acc_q   <= acc_d;
      hc_s_q  <= hc_s_d;
      co_s_q  <= co_s_d;
      v_s_q   <= v_s_d;
      out_q   <= out_d;
      co_q    <= co_d;
      hc_q    <= hc_d;
      v_q     <= v_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = done_q;
  assign bus.out  = out_q;
  assign bus.co   = co_q;
  assign bus.hc   = hc_q;
  assign bus.v    = v_q;
  assign bus.n    = out_q[WIDTH-1];
  assign bus.z    = (out_q == '0);

endmodule

// File: doc/nibble_serial_alu.md
Name: nibble_serial_alu

Overview:
- Parametrised, multi-cycle successor to the 8-bit CPU ALU. It keeps the same op encoding, logic/shift/add structure and flag semantics.
- The adder is nibble-serial: one 4-bit digit per clock, LSB first. Any WIDTH that is a multiple of 4 is supported.
- Adds full decimal correction for both BCD add and BCD subtract.
- Sits beside the CPU core as a shared arithmetic unit, with a start/busy/done handshake and a global RDY stall.

Parameters:
- WIDTH, 8, operand/result width in bits; multiple of 4, range 4..32.
- DIGITS, WIDTH/4, localparam, number of nibble-serial adder steps.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rdy  in  1  global clock enable; low freezes every register.
- start  in  1  request; sampled only when rdy=1 and the block is idle.
- op  in  4  0011 A+B, 0111 A-B, 1011 A+A, 1100 A|B, 1101 A&B, 1110 A^B, 1111 A.
- right  in  1  rotate-right through carry, replacing the logic result.
- ai  in  WIDTH  operand A.
- bi  in  WIDTH  operand B.
- ci  in  1  carry in (borrow-not for subtract).
- bcd  in  1  decimal mode for 0011/0111.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; result and flags valid from this cycle on.
- out  out  WIDTH  result.
- co  out  1  carry out (decimally adjusted when bcd=1).
- hc  out  1  carry out of nibble 0 (adjusted).
- v  out  1  overflow.
- n  out  1  out[WIDTH-1].
- z  out  1  out==0, combinational from out.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; busy=0, done=0.
  - out=0, co=0, hc=0, v=0, n=0, hence z=1.
  - Reset during CALC aborts the operation; nothing is retained.
- FSM IDLE -> CALC -> DONE -> IDLE. No transition occurs while rdy=0.
- IDLE:
  - start=1 with rdy=1 latches ai, bi, ci, op, right, bcd and computes the logic stage.
  - Logic stage by op[1:0]: 00 OR, 01 AND, 10 XOR, 11 A.
  - If right=1, logic = {ai[0], ci, ai[WIDTH-1:1]} (WIDTH+1 bits; bit WIDTH feeds the adder carry position).
  - Effective B by op[3:2]: 00 bi, 01 ~bi, 10 logic, 11 zero.
  - adder_ci = 0 when right=1 or op[3:2]=11; otherwise ci.
  - Go to CALC with digit index k=0.
- CALC, one nibble per rdy-cycle:
  - s = L[k] + Beff[k] + c, 5-bit sum.
  - bcd=1 with op 0011: if s>9, digit=(s+6)&0xF and carry=1.
  - bcd=1 with op 0111: if s[4]=0 (borrow), digit=(s+10)&0xF and carry=0.
  - Otherwise digit=s[3:0], carry=s[4].
  - At k=0, capture hc=carry.
  - At k=DIGITS-1:
    - The top logic bit (right shift) is added to the final carry.
    - v = ai[W-1] ^ Beff[W-1] ^ binary carry-out ^ binary sum[W-1], using pre-correction values.
    - Go to DONE.
- DONE: outputs update; done=1 for one cycle; go to IDLE.
- Outputs hold until the next DONE. Partial digits accumulate internally and are never visible on out.
- Latency: start accepted at edge t gives done at edge t+DIGITS+1 (8-bit: 3 cycles). Each rdy=0 cycle adds one.
- start while busy or done is ignored; no queueing.
- Logic ops (1100..1111) and right shifts still traverse CALC: uniform latency, with B=0 passing the logic result through.
- bcd=1 with non-add/sub ops has no effect.
- Non-BCD input digits (>9) in decimal mode produce a defined but unspecified-value result; no error flag.

Decomposition:
- Package alu_pkg:
  - op encoding constants (OP_ADD, OP_SUB, OP_ASL, OP_OR, OP_AND, OP_EOR, OP_PASS).
  - FSM state enum.
  - WIDTH legality check (WIDTH%4==0).
- Sub-module bcd_nibble_adder: combinational 4-bit add with carry in and decimal adjust.
  - Inputs: a, b, ci, bcd, sub.
  - Outputs: digit, carry, bin_carry, bin_msb.
  - Instantiated once and reused serially across digits.

Test Plan:
- WIDTH=8, op=0011, bcd=1, ai=0x45, bi=0x38, ci=0 -> out=0x83, hc=1, co=0, done exactly 3 cycles after start.
- WIDTH=8, op=0111, bcd=1, ai=0x42, bi=0x15, ci=1 -> out=0x27, hc=0, co=1.
- WIDTH=8, op=0011, bcd=0, ai=0x7F, bi=0x01, ci=0 -> out=0x80, v=1, n=1, hc=1, co=0, z=0.
- WIDTH=8, op=1111, right=1, ai=0x81, ci=1 -> out=0xC0, co=1; then op=1111, ai=0x00 -> z=1.
- WIDTH=16, op=0011, bcd=1, ai=0x9999, bi=0x0001 -> out=0x0000, co=1, z=1. With rdy low for 3 cycles mid-CALC, done arrives at t+8 instead of t+5; a second start while busy is ignored.
- Assert rst_n low mid-CALC -> busy=0 and out=0 immediately; no done pulse; the next start completes normally.
